lut_interp_activation_pipe: RTL
===============================

// Module: lut_interp_activation_pipe
// PURPOSE
//   Pipelined, multi-lane piecewise-linear activation unit for neuron layers: the upper ADDR_W bits of
//   each input select a segment of a runtime-loadable LUT, and the FRAC_W remainder bits linearly
//   interpolate between that segment's two endpoints. Sits between the MAC accumulator output
//   (z value) and the next layer's input, with valid/ready flow control in both directions.
// PARAMETERS
//   DATA_W  8  signed width of each input z value, LUT entry and output activation
//   ADDR_W  4  LUT index bits; the LUT holds 2**ADDR_W+1 entries; FRAC_W = DATA_W-ADDR_W (>=1)
//   LANES   1  parallel lanes; all lanes share one LUT, each lane has its own read ports
// PORTS
//   clk        in   1              rising-edge clock
//   rst_n      in   1              asynchronous reset, active low
//   in_valid   in   1              input beat valid
//   in_ready   out  1              unit can accept a beat this cycle
//   in_data    in   LANES*DATA_W   lane k = bits [k*DATA_W +: DATA_W], signed z value
//   out_valid  out  1              output beat valid
//   out_ready  in   1              downstream accepts output
//   out_data   out  LANES*DATA_W   signed activations, same lane packing as in_data
//   lut_we     in   1              LUT write strobe
//   lut_addr   in   ADDR_W+1       LUT entry index, 0..2**ADDR_W
//   lut_wdata  in   DATA_W         signed entry value
//   busy       out  1              any pipeline stage holds a valid beat
//   cfg_err    out  1              sticky: a LUT write was dropped (write while busy, or addr > 2**ADDR_W)
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valid bits 0; out_valid=0; out_data=0; busy=0; cfg_err=0;
//     all LUT entries 0. in_ready=1 from the first clock edge after reset release.
//   Pipeline: three stages, S1 -> S2 -> S3, with a global advance = out_ready | ~S3.valid.
//     in_ready = advance; a beat is taken when in_valid & in_ready. Latency is exactly 3 cycles
//     from acceptance to out_valid when out_ready stays high; throughput is 1 beat/cycle.
//     When advance=0, every stage holds its contents and out_data stays stable (no bubble collapse).
//   S1: register the input. Per lane, idx = z[DATA_W-1:FRAC_W], taken as an unsigned index
//       (two's-complement bit pattern), and rem = z[FRAC_W-1:0], unsigned.
//   S2: base = LUT[idx]; next = LUT[idx+1]. idx+1 is computed in ADDR_W+1 bits, so idx = 2**ADDR_W-1
//       reads extra entry 2**ADDR_W (no wrap). Register diff = next - base (DATA_W+1 bits, signed).
//   S3: out = base + ((diff * rem) >>> FRAC_W). The product is signed DATA_W+FRAC_W+2 bits; the shift
//       is arithmetic (floor toward -inf). The result always lies between base and next, so it is
//       truncated to DATA_W bits with no saturation.
//   LUT write: accepted only when busy=0 and in_valid=0 in the same cycle; the entry updates on that
//     edge. Otherwise the write is dropped and cfg_err is set. cfg_err clears only on reset.
//     In a cycle with lut_we=1 and in_valid=1, the input beat wins and the write is dropped.
//   busy = S1.valid | S2.valid | S3.valid.
//   Lanes are fully independent except for the shared LUT contents and the shared handshake.
//   Reset asserted mid-stream: in-flight beats are discarded and LUT contents are cleared.
// TESTING
//   1) Load LUT[i]=4*i for i=0..16; send z=0x35 -> out=13 (base 12, diff 4, 4*5>>4=1),
//      exactly 3 cycles after acceptance.
//   2) Load LUT[3]=20, LUT[4]=-20; send z=0x35 -> out=7 (diff -40, -200>>>4 = -13, 20-13).
//   3) Ramp LUT from test 1; send z=0xF8 (idx 15, rem 8) -> reads LUT[16]=64; out=62.
//      Send z=0x80 -> idx 8, out=32.
//   4) LANES=4, streaming 100 random beats with out_ready toggled randomly -> results match the
//      golden model in order; no beat lost or duplicated; out_data stable while out_valid & ~out_ready.
//   5) lut_we while busy=1, and lut_we with lut_addr=17 -> LUT unchanged, cfg_err=1 until reset;
//      lut_we coincident with accepted in_valid -> write dropped.
//   6) Assert rst_n low with 3 beats in flight -> out_valid=0 and busy=0 immediately; LUT reads 0;
//      after release, z=0x35 -> out=0.

Source files
------------

// File: rtl/lut_interp_activation_pipe_if.sv
// Stream + LUT-config bundle for the piecewise-linear activation pipe.
// The master drives beats and LUT writes; the slave is the pipe.
interface lut_interp_activation_pipe_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LANES  = 1
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    lut_we;
  logic [ADDR_W:0]         lut_addr;
  logic [DATA_W-1:0]       lut_wdata;
  logic                    busy;
  logic                    cfg_err;

  modport master (
    output in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
    input  in_ready, out_valid, out_data, busy, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, lut_we, lut_addr, lut_wdata,
    output in_ready, out_valid, out_data, busy, cfg_err
  );
endinterface

// File: rtl/lut_interp_activation_pipe.sv
// Multi-lane LUT-interpolated activation: S1 split z, S2 fetch base/diff,
// S3 base + (diff*rem)>>>FRAC_W. One shared LUT, per-lane read ports.
module lut_interp_lane #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LUT_N  = 17
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           adv_i,
  input  logic [DATA_W-1:0]              z_i,
  input  logic [LUT_N-1:0][DATA_W-1:0]   lut_i,
  output logic [DATA_W-1:0]              act_o
);
  localparam int FRAC_W = DATA_W - ADDR_W;
  localparam int PW     = DATA_W + FRAC_W + 2;

  logic [ADDR_W-1:0] idx_q;
  logic [FRAC_W-1:0] rem1_q, rem2_q;
  logic [DATA_W-1:0] base_q, act_q;
  logic [DATA_W:0]   diff_q;

  logic [ADDR_W:0]   idx_w, idx_nx;
  logic [DATA_W-1:0] base_d, next_d, act_d;
  logic [DATA_W:0]   diff_d;
  logic signed [PW-1:0] diff_x, rem_x, prod, shr;

  // idx+1 is one bit wider so the top segment reads the extra endpoint
  assign idx_w  = {1'b0, idx_q};
  assign idx_nx = idx_w + (ADDR_W+1)'(1);
  assign base_d = lut_i[idx_w];
  assign next_d = lut_i[idx_nx];
  assign diff_d = {next_d[DATA_W-1], next_d} - {base_d[DATA_W-1], base_d};

  assign diff_x = {{(PW-DATA_W-1){diff_q[DATA_W]}}, diff_q};
  assign rem_x  = {{(PW-FRAC_W){1'b0}}, rem2_q};
  assign prod   = diff_x * rem_x;
  assign shr    = prod >>> FRAC_W;
  // result sits between base and next, so plain truncation is exact
  assign act_d  = base_q + DATA_W'(shr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      rem1_q <= '0;
      rem2_q <= '0;
      base_q <= '0;
      diff_q <= '0;
      act_q  <= '0;
    end else if (adv_i) begin
      idx_q  <= z_i[DATA_W-1:FRAC_W];
      rem1_q <= z_i[FRAC_W-1:0];
      base_q <= base_d;
      diff_q <= diff_d;
      rem2_q <= rem1_q;
      act_q  <= act_d;
    end
  end

  assign act_o = act_q;
endmodule

module lut_interp_activation_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int LANES  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lut_interp_activation_pipe_if.slave io
);
  localparam int LUT_N  = (1 << ADDR_W) + 1;
  localparam int STAGES = 3;

  logic [LUT_N-1:0][DATA_W-1:0] lut_q;
  logic [STAGES:1]              vld_pipe_q;
  logic                         cfg_err_q;
  logic                         adv, in_fire, busy, wr_ok;
  logic [LANES-1:0][DATA_W-1:0] lane_z, lane_act;

  // no bubble collapse: the whole pipe stalls when the output is blocked
  assign adv     = io.out_ready | ~vld_pipe_q[STAGES];
  assign in_fire = io.in_valid & adv;
  assign busy    = |vld_pipe_q;
  // the LUT only changes when nothing is in flight or arriving
  assign wr_ok   = io.lut_we & ~busy & ~io.in_valid &
                   (io.lut_addr <= (ADDR_W+1)'(LUT_N-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      lut_q      <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      if (adv) vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_fire};
      if (wr_ok) lut_q[io.lut_addr] <= io.lut_wdata;
      if (io.lut_we && !wr_ok) cfg_err_q <= 1'b1;
    end
  end

  assign lane_z = io.in_data;

  lut_interp_lane #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LUT_N (LUT_N)
  ) u_lane [LANES-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .adv_i(adv),
    .z_i  (lane_z),
    .lut_i(lut_q),
    .act_o(lane_act)
  );

  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe_q[STAGES];
  assign io.out_data  = lane_act;
  assign io.busy      = busy;
  assign io.cfg_err   = cfg_err_q;
endmodule
